alu_divider_rv32im: RTL

Iterative restoring divider for the RV32IM M-extension ops DIV, DIVU, REM and REMU. It sits beside the combinational ALU in the execute stage and is started by a one-cycle request. It runs one compare-and-subtract step per cycle and returns the 32-bit quotient or remainder with a done pulse. RISC-V divide-by-zero and signed-overflow results are produced in a short path without iterating.

---
 rtl/alu_rv32im_pkg.sv | 27 ++
 rtl/alu_div_step.sv | 19 +
 rtl/alu_divider_rv32im.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_rv32im_pkg.sv
// Shared types for the RV32IM divide unit.
// Op encoding follows funct3[1:0] of the M-extension divide group.
package alu_rv32im_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_STEPS = 32;

    function automatic logic [31:0] neg_if(
        input logic        n,
        input logic [31:0] v
    );
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// The partial remainder never reaches 2^32, so 32 bits hold it.
module alu_div_step (
    input  logic [31:0] rem,
    input  logic        dbit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        qbit
);

    logic [32:0] shifted;
    logic [32:0] trial;

    assign shifted  = {rem, dbit};
    assign trial    = shifted - {1'b0, divisor};
    assign qbit     = ~trial[32];
    assign rem_next = qbit ? trial[31:0] : shifted[31:0];

endmodule

// File: rtl/alu_divider_rv32im.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish without iterating.
module alu_divider_rv32im
    import alu_rv32im_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] result
);

    div_state_t  state;
    div_op_t     op_q;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_b;
    logic [31:0] rem;
    logic [31:0] q;
    logic [4:0]  count;
    logic [31:0] result_q;

    logic        in_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        b_zero;
    logic        ovf;
    logic [31:0] special_res;

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & operand_A[31];
    assign b_neg     = in_signed & operand_B[31];
    assign abs_a     = neg_if(a_neg, operand_A);
    assign abs_b     = neg_if(b_neg, operand_B);
    assign b_zero    = (operand_B == 32'h0);
    assign ovf       = in_signed
                     & (operand_A == 32'h8000_0000)
                     & (operand_B == 32'hFFFF_FFFF);

    // Divide-by-zero wins over overflow; remainder of /0 is the raw dividend
    always_comb begin
        special_res = 32'h0;
        unique case (1'b1)
            b_zero:  special_res = op[1] ? operand_A : 32'hFFFF_FFFF;
            default: special_res = op[1] ? 32'h0 : 32'h8000_0000;
        endcase
    end

    logic [31:0] rem_nx;
    logic        q_bit;
    logic [31:0] q_nx;
    logic        op_signed;
    logic [31:0] fin_q;
    logic [31:0] fin_r;
    logic [31:0] fin_res;

    alu_div_step u_step (
        .rem      (rem),
        .dbit     (q[31]),
        .divisor  (mag_b),
        .rem_next (rem_nx),
        .qbit     (q_bit)
    );

    assign q_nx      = {q[30:0], q_bit};
    assign op_signed = ~op_q[0];
    assign fin_q     = neg_if(op_signed & (sign_a ^ sign_b), q_nx);
    assign fin_r     = neg_if(op_signed & sign_a, rem_nx);
    assign fin_res   = op_q[1] ? fin_r : fin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= DIV;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_b    <= 32'h0;
            rem      <= 32'h0;
            q        <= 32'h0;
            count    <= 5'd0;
            result_q <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= div_op_t'(op);
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        mag_b  <= abs_b;
                        rem    <= 32'h0;
                        q      <= abs_a;
                        count  <= 5'd0;
                        if (b_zero || ovf) begin
                            result_q <= special_res;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_nx;
                    q     <= q_nx;
                    count <= count + 5'd1;
                    // Last step: fold the sign fix-up into the same edge
                    if (count == 5'(DIV_STEPS - 1)) begin
                        result_q <= fin_res;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule
